avalon_vector_reduce: RTL and testbench

- Custom Avalon-MM peripheral that sits in the Nios system beside the SDRAM controller.
- The CPU programs a source address, a length and a mode through a CSR slave; the block then reads the vector from SDRAM through its own pipelined read master.
- It reduces the vector to one result: unsigned sum, signed sum, maximum or minimum.
- It is the parametrised, hardware-accelerated successor to the software-only loop in the current Nios build.

---
 rtl/avalon_vector_reduce.sv | 226 ++++++++++++++++++++++
 tb/tb_avalon_vector_reduce.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_vector_reduce.sv
`default_nettype none
// ============================================================================
// Module   : avalon_vector_reduce
// Purpose  : Avalon-MM vector reduction engine. The CPU programs a source
//            address, an element count and a reduction mode through the CSR
//            slave. A pipelined read master then fetches the vector and
//            reduces it to one result: unsigned sum, signed sum, unsigned
//            maximum or unsigned minimum.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_50          in   system clock (single clock domain)
//   reset_n         in   asynchronous active-low reset
//   s_address[2:0]  in   CSR word address
//   s_read          in   CSR read strobe (data returned one cycle later)
//   s_write         in   CSR write strobe
//   s_writedata     in   CSR write data
//   s_readdata      out  CSR read data
//   irq             out  level interrupt, DONE & IRQ_EN (registered)
//   m_address       out  master byte address
//   m_read          out  master read request
//   m_waitrequest   in   master stall
//   m_readdata      in   master read data (one element)
//   m_readdatavalid in   master read data valid
// CSR map
//   0 CTRL      bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN
//   1 STATUS    bit0 BUSY (RO), bit1 DONE (W1C)
//   2 SRC       byte address, element aligned
//   3 LEN       element count
//   4 MODE      0 usum, 1 ssum, 2 umax, 3 umin
//   5 RESULT_LO result[31:0]
//   6 RESULT_HI result[ACC_W-1:32], zero-extended
//   7 reserved, reads 0
// ============================================================================
module avalon_vector_reduce #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 24,
    parameter int ACC_W    = 48,
    parameter int MAX_PEND = 8
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic [2:0]        s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid
);

    localparam int                BYTES        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] C_STEP       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~(ADDR_W'(BYTES - 1));
    localparam logic [LEN_W-1:0]  C_MAX_PEND   = LEN_W'(MAX_PEND);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_irq_en;
    logic              r_done;
    logic              r_irq;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_received;
    logic [1:0]        r_mode;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_result;
    logic              r_read;
    logic [31:0]       r_readdata;

    logic              w_busy;
    logic              w_start;
    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic              w_first;
    logic [LEN_W-1:0]  w_issued_nx;
    logic [LEN_W-1:0]  w_received_nx;
    logic [LEN_W-1:0]  w_pend_nx;
    logic [ACC_W-1:0]  w_elem_u;
    logic [ACC_W-1:0]  w_elem_s;
    logic [ACC_W-1:0]  w_acc_nx;
    logic [31:0]       w_rd_data;
    logic [31:0]       w_result_hi;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_start  = s_write && (s_address == 3'd0) && s_writedata[0] && !w_busy;
    assign w_accept = r_read && !m_waitrequest;
    // Beats outside RUN belong to reads issued before a reset and are dropped.
    assign w_beat   = m_readdatavalid && (r_state == ST_RUN);

    assign w_issued_nx   = r_issued + LEN_W'(w_accept);
    assign w_received_nx = r_received + LEN_W'(w_beat);
    assign w_pend_nx     = w_issued_nx - w_received_nx;
    assign w_last        = w_beat && (w_received_nx == r_len);
    assign w_first       = (r_received == '0);

    assign w_elem_u = {{(ACC_W - DATA_W){1'b0}}, m_readdata};
    assign w_elem_s = {{(ACC_W - DATA_W){m_readdata[DATA_W-1]}}, m_readdata};

    // Max/min seed the accumulator with the first element of the run.
    always_comb begin
        w_acc_nx = r_acc;
        case (r_mode)
            2'd0:    w_acc_nx = r_acc + w_elem_u;
            2'd1:    w_acc_nx = r_acc + w_elem_s;
            2'd2:    if (w_first || (w_elem_u > r_acc)) w_acc_nx = w_elem_u;
            default: if (w_first || (w_elem_u < r_acc)) w_acc_nx = w_elem_u;
        endcase
    end

    assign w_result_hi = 32'(r_result >> 32);

    always_comb begin
        w_rd_data = '0;
        case (s_address)
            3'd0:    w_rd_data = {30'd0, r_irq_en, 1'b0};
            3'd1:    w_rd_data = {30'd0, r_done, w_busy};
            3'd2:    w_rd_data = 32'(r_src);
            3'd3:    w_rd_data = 32'(r_len);
            3'd4:    w_rd_data = {30'd0, r_mode};
            3'd5:    w_rd_data = r_result[31:0];
            3'd6:    w_rd_data = w_result_hi;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_irq      <= 1'b0;
            r_src      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_mode     <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_read     <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_readdata <= s_read ? w_rd_data : 32'd0;
            r_irq      <= r_done && r_irq_en;

            if (s_write) begin
                case (s_address)
                    3'd0: r_irq_en <= s_writedata[1];
                    3'd1: if (s_writedata[1]) r_done <= 1'b0;
                    3'd2: if (!w_busy) r_src  <= ADDR_W'(s_writedata) & C_ALIGN_MASK;
                    3'd3: if (!w_busy) r_len  <= LEN_W'(s_writedata);
                    3'd4: if (!w_busy) r_mode <= s_writedata[1:0];
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (r_len != '0) begin
                            r_state    <= ST_RUN;
                            r_done     <= 1'b0;
                            r_issued   <= '0;
                            r_received <= '0;
                            r_addr     <= r_src;
                            r_acc      <= '0;
                            r_read     <= 1'b1;
                        end else begin
                            // Empty vector: complete at once with a zero result.
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_issued   <= w_issued_nx;
                    r_received <= w_received_nx;
                    if (w_accept) begin
                        r_addr <= r_addr + C_STEP;
                    end
                    if (w_beat) begin
                        r_acc <= w_acc_nx;
                    end
                    if (w_last) begin
                        r_state <= ST_FINISH;
                        r_read  <= 1'b0;
                    end else begin
                        // Looking at next-cycle counts drops m_read in the very
                        // cycle the outstanding window fills.
                        r_read <= (w_issued_nx < r_len) && (w_pend_nx < C_MAX_PEND);
                    end
                end
                ST_FINISH: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    assign s_readdata = r_readdata;
    assign irq        = r_irq;
    assign m_address  = r_addr;
    assign m_read     = r_read;

endmodule
`default_nettype wire

// File: tb/tb_avalon_vector_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_vector_reduce
// Purpose  : Self-checking bench for avalon_vector_reduce. Two instances run
//            side by side on a shared CSR bus and reset: instance A with
//            32-bit elements and a 33-bit accumulator, instance B with 8-bit
//            elements and a 48-bit accumulator. Each has its own randomised
//            memory responder; results are checked against a reference
//            reduction computed directly from the element list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_vector_reduce;

    localparam int MAXP = 8;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic [2:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata [2];
    logic        irq [2];
    logic [31:0] m_address [2];
    logic        m_read [2];
    logic        m_waitrequest [2];
    logic [31:0] m_readdata [2];
    logic        m_readdatavalid [2];

    always #5 clk_50 = ~clk_50;

    avalon_vector_reduce #(.DATA_W(32), .ADDR_W(32), .LEN_W(24), .ACC_W(33), .MAX_PEND(MAXP)) u_dut_a (
        .clk_50(clk_50), .reset_n(reset_n),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata[0]), .irq(irq[0]),
        .m_address(m_address[0]), .m_read(m_read[0]), .m_waitrequest(m_waitrequest[0]),
        .m_readdata(m_readdata[0]), .m_readdatavalid(m_readdatavalid[0])
    );

    avalon_vector_reduce #(.DATA_W(8), .ADDR_W(32), .LEN_W(24), .ACC_W(48), .MAX_PEND(MAXP)) u_dut_b (
        .clk_50(clk_50), .reset_n(reset_n),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata[1]), .irq(irq[1]),
        .m_address(m_address[1]), .m_read(m_read[1]), .m_waitrequest(m_waitrequest[1]),
        .m_readdata(m_readdata[1][7:0]), .m_readdatavalid(m_readdatavalid[1])
    );

    // ---------------- shared bench state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] vec [64];
    logic [31:0] cur_src;
    bit          rnd_wait;
    int          lat_lo;
    int          lat_hi;
    logic [31:0] exp_addr [2];
    int          acc_cnt [2];
    int          beat_cnt [2];
    int          max_pend_seen [2];
    bit          read_seen [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dw_of(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic int aw_of(input int k);
        return (k == 0) ? 33 : 48;
    endfunction

    function automatic logic [31:0] elem_at(input int k, input logic [31:0] a);
        logic [31:0] off;
        int          idx;
        off = a - cur_src;
        idx = (k == 0) ? int'(off >> 2) : int'(off);
        return vec[idx & 63] & ((k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF);
    endfunction

    // Reference reduction straight from the mode definitions.
    function automatic logic [63:0] ref_red(input int k, input int mode, input int len);
        logic [63:0] acc;
        logic [63:0] e;
        int          dw;
        dw  = dw_of(k);
        acc = '0;
        for (int i = 0; i < len; i++) begin
            e = 64'(vec[i]) & ((64'd1 << dw) - 1);
            case (mode)
                0: acc = acc + e;
                1: acc = e[dw-1] ? acc + e - (64'd1 << dw) : acc + e;
                2: if (i == 0 || e > acc) acc = e;
                default: if (i == 0 || e < acc) acc = e;
            endcase
        end
        return acc & ((64'd1 << aw_of(k)) - 1);
    endfunction

    // ---------------- memory responders ----------------
    generate
        for (genvar k = 0; k < 2; k++) begin : g_resp
            int unsigned cyc;
            int unsigned q_due [$];
            logic [31:0] q_data [$];
            int          pend;
            initial begin
                cyc                = 0;
                m_waitrequest[k]   = 1'b0;
                m_readdatavalid[k] = 1'b0;
                m_readdata[k]      = '0;
            end
            // Everything is driven on the falling edge, for the next rising edge.
            always @(negedge clk_50) begin
                cyc = cyc + 1;
                if (m_read[k]) read_seen[k] = 1'b1;
                if (q_due.size() > 0 && q_due[0] <= cyc) begin
                    m_readdatavalid[k] = 1'b1;
                    m_readdata[k]      = q_data.pop_front();
                    void'(q_due.pop_front());
                    beat_cnt[k]++;
                end else begin
                    m_readdatavalid[k] = 1'b0;
                    m_readdata[k]      = $urandom;
                end
                m_waitrequest[k] = rnd_wait && ($urandom_range(0, 2) == 0);
                if (m_read[k] && !m_waitrequest[k]) begin
                    check($sformatf("addr_%0d", k), 64'(m_address[k]), 64'(exp_addr[k]));
                    q_data.push_back(elem_at(k, m_address[k]));
                    q_due.push_back(cyc + 1 + $urandom_range(lat_lo, lat_hi));
                    exp_addr[k] = exp_addr[k] + 32'(dw_of(k) / 8);
                    acc_cnt[k]++;
                end
                pend = acc_cnt[k] - beat_cnt[k];
                if (pend > max_pend_seen[k]) max_pend_seen[k] = pend;
            end
        end
    endgenerate

    // ---------------- CSR access ----------------
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk_50);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        @(posedge clk_50);
        #1;
        s_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
        @(negedge clk_50);
        s_address = a;
        s_read    = 1'b1;
        @(posedge clk_50);
        #1;
        s_read = 1'b0;
        ra = s_readdata[0];
        rb = s_readdata[1];
    endtask

    task automatic wait_idle();
        logic [31:0] a, b;
        for (int n = 0; n < 2000; n++) begin
            csr_rd(3'd1, a, b);
            if (!a[0] && !b[0]) break;
        end
        check("busy_after_wait", {62'd0, b[0], a[0]}, 64'd0);
    endtask

    task automatic start_run(input logic [31:0] src, input int len, input int mode, input logic [31:0] ctrl);
        csr_wr(3'd2, src);
        csr_wr(3'd3, 32'(len));
        csr_wr(3'd4, 32'(mode));
        cur_src = src;
        for (int k = 0; k < 2; k++) begin
            exp_addr[k]      = src;
            acc_cnt[k]       = 0;
            beat_cnt[k]      = 0;
            max_pend_seen[k] = 0;
        end
        csr_wr(3'd0, ctrl | 32'd1);
    endtask

    task automatic check_run(input string tag, input int len, input int mode);
        logic [31:0] a, b;
        logic [63:0] ra, rb;
        wait_idle();
        ra = ref_red(0, mode, len);
        rb = ref_red(1, mode, len);
        csr_rd(3'd1, a, b);
        check({tag, "_status_a"}, 64'(a), 64'd2);
        check({tag, "_status_b"}, 64'(b), 64'd2);
        csr_rd(3'd5, a, b);
        check({tag, "_lo_a"}, 64'(a), ra & 64'hFFFF_FFFF);
        check({tag, "_lo_b"}, 64'(b), rb & 64'hFFFF_FFFF);
        csr_rd(3'd6, a, b);
        check({tag, "_hi_a"}, 64'(a), ra >> 32);
        check({tag, "_hi_b"}, 64'(b), rb >> 32);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_issued_%0d", tag, k), 64'(acc_cnt[k]), 64'(len));
            check($sformatf("%s_pend_ok_%0d", tag, k), 64'(max_pend_seen[k] <= MAXP), 64'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        int          len;
        int          mode;

        reset_n     = 1'b0;
        s_address   = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = '0;
        rnd_wait    = 1'b0;
        lat_lo      = 0;
        lat_hi      = 0;
        cur_src     = '0;
        for (int k = 0; k < 2; k++) begin
            exp_addr[k] = '0; acc_cnt[k] = 0; beat_cnt[k] = 0;
            max_pend_seen[k] = 0; read_seen[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk_50);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_m_read_%0d", k), 64'(m_read[k]), 64'd0);
            check($sformatf("rst_m_addr_%0d", k), 64'(m_address[k]), 64'd0);
            check($sformatf("rst_irq_%0d", k), 64'(irq[k]), 64'd0);
            check($sformatf("rst_rdata_%0d", k), 64'(s_readdata[k]), 64'd0);
        end
        @(negedge clk_50);
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            csr_rd(3'(r), a, b);
            check($sformatf("rst_csr%0d_a", r), 64'(a), 64'd0);
            check($sformatf("rst_csr%0d_b", r), 64'(b), 64'd0);
        end

        // Sum of 16 elements, no stalls
        for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
        start_run(32'h100, 16, 0, 32'd0);
        check_run("sum16", 16, 0);

        // Signed sum, random stalls and latency from here on
        rnd_wait = 1'b1;
        lat_hi   = 5;
        vec[0] = 32'hFF; vec[1] = 32'hFF; vec[2] = 32'h05;
        start_run(32'h200, 3, 1, 32'd0);
        check_run("ssum", 3, 1);

        // Max and min
        vec[0] = 32'd7; vec[1] = 32'hFFFF_FFF0; vec[2] = 32'd3;
        start_run(32'h240, 3, 2, 32'd0);
        check_run("max", 3, 2);
        start_run(32'h240, 3, 3, 32'd0);
        check_run("min", 3, 3);

        // Accumulator wrap
        for (int i = 0; i < 3; i++) vec[i] = 32'hFFFF_FFFF;
        start_run(32'h400, 3, 0, 32'd0);
        check_run("wrap", 3, 0);

        // Zero length with interrupt
        csr_wr(3'd1, 32'd2);
        csr_rd(3'd1, a, b);
        check("zl_pre_status_a", 64'(a), 64'd0);
        check("zl_pre_status_b", 64'(b), 64'd0);
        csr_wr(3'd3, 32'd0);
        read_seen[0] = 1'b0;
        read_seen[1] = 1'b0;
        csr_wr(3'd0, 32'd3);
        check("zl_irq_c2_a", 64'(irq[0]), 64'd0);
        check("zl_irq_c2_b", 64'(irq[1]), 64'd0);
        @(posedge clk_50);
        #1;
        check("zl_irq_c3_a", 64'(irq[0]), 64'd1);
        check("zl_irq_c3_b", 64'(irq[1]), 64'd1);
        csr_rd(3'd1, a, b);
        check("zl_status_a", 64'(a), 64'd2);
        check("zl_status_b", 64'(b), 64'd2);
        csr_rd(3'd5, a, b);
        check("zl_res_lo_a", 64'(a), 64'd0);
        check("zl_res_lo_b", 64'(b), 64'd0);
        csr_rd(3'd6, a, b);
        check("zl_res_hi_a", 64'(a), 64'd0);
        check("zl_no_read_a", 64'(read_seen[0]), 64'd0);
        check("zl_no_read_b", 64'(read_seen[1]), 64'd0);
        csr_wr(3'd1, 32'd2);
        @(posedge clk_50);
        #1;
        check("zl_w1c_irq_a", 64'(irq[0]), 64'd0);
        check("zl_w1c_irq_b", 64'(irq[1]), 64'd0);
        csr_wr(3'd0, 32'd3);
        repeat (2) @(posedge clk_50);
        #1;
        check("zl2_irq_a", 64'(irq[0]), 64'd1);
        csr_wr(3'd0, 32'd0);
        @(posedge clk_50);
        #1;
        check("irqen_clr_a", 64'(irq[0]), 64'd0);
        check("irqen_clr_b", 64'(irq[1]), 64'd0);

        // Guard rules: CSR writes and START while busy
        for (int i = 0; i < 16; i++) vec[i] = $urandom;
        start_run(32'h300, 16, 0, 32'd0);
        csr_wr(3'd3, 32'd2);
        csr_wr(3'd2, 32'h800);
        csr_wr(3'd4, 32'd3);
        csr_wr(3'd0, 32'd1);
        check_run("guard", 16, 0);
        csr_rd(3'd2, a, b);
        check("guard_src_a", 64'(a), 64'h300);
        check("guard_src_b", 64'(b), 64'h300);
        csr_rd(3'd3, a, b);
        check("guard_len_a", 64'(a), 64'd16);
        csr_rd(3'd4, a, b);
        check("guard_mode_a", 64'(a), 64'd0);

        // Random runs, the last one wrapping the address space
        for (int t = 0; t < 5; t++) begin
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 64; i++) vec[i] = $urandom;
            if (t == 4) begin
                start_run(32'hFFFF_FFF8, 6, mode, 32'd0);
                check_run("addrwrap", 6, mode);
            end else begin
                start_run({$urandom_range(0, 32'hFFF), 8'h00}, len, mode, 32'd0);
                check_run($sformatf("rand%0d", t), len, mode);
            end
        end

        // Reset in the middle of a run
        rnd_wait = 1'b0;
        lat_lo   = 12;
        lat_hi   = 12;
        for (int i = 0; i < 32; i++) vec[i] = 32'(i + 1);
        start_run(32'h100, 20, 0, 32'd0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_50);
            #1;
            if (acc_cnt[0] - beat_cnt[0] >= 4) break;
        end
        check("mid_pend_reached", 64'(acc_cnt[0] - beat_cnt[0] >= 4), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_m_read_a", 64'(m_read[0]), 64'd0);
        check("mid_rst_m_read_b", 64'(m_read[1]), 64'd0);
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            csr_rd(3'(r), a, b);
            check($sformatf("mid_csr%0d_a", r), 64'(a), 64'd0);
            check($sformatf("mid_csr%0d_b", r), 64'(b), 64'd0);
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_50);
            #1;
            if (acc_cnt[0] == beat_cnt[0] && acc_cnt[1] == beat_cnt[1]) break;
        end
        csr_rd(3'd1, a, b);
        check("late_status_a", 64'(a), 64'd0);
        check("late_status_b", 64'(b), 64'd0);
        csr_rd(3'd5, a, b);
        check("late_res_a", 64'(a), 64'd0);
        check("late_res_b", 64'(b), 64'd0);
        rnd_wait = 1'b1;
        lat_lo   = 0;
        lat_hi   = 5;
        for (int i = 0; i < 4; i++) vec[i] = $urandom;
        start_run(32'h100, 4, 0, 32'd0);
        check_run("post_rst", 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
